// File: rtl/grid_scatter_2d.sv
// Visibility gridding front-end: pops one sample from a FWFT FIFO and walks the
// full SSIZE x SSIZE kernel support, emitting one (gind, cind, data) beat per point.
module grid_scatter_2d #(
   parameter int GSIZE_BITS = 5,
   parameter int SUPPORT    = 7,
   parameter int PRECISION  = 32,
   parameter int IDX_WIDTH  = 16,
   parameter bit WRAP       = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 empty,
   input  logic [IDX_WIDTH-1:0] iu,
   input  logic [IDX_WIDTH-1:0] iv,
   input  logic [IDX_WIDTH-1:0] offset,
   input  logic [PRECISION-1:0] indatar,
   input  logic [PRECISION-1:0] indatai,
   output logic                 read,
   input  logic                 out_ready,
   output logic                 valid,
   output logic [IDX_WIDTH-1:0] gind,
   output logic [IDX_WIDTH-1:0] cind,
   output logic [PRECISION-1:0] outdatar,
   output logic [PRECISION-1:0] outdatai,
   output logic                 busy,
   output logic [15:0]          sample_count
);

   localparam int SSIZE = 2 * SUPPORT + 1;
   localparam int CW    = GSIZE_BITS + 2;
   localparam int RC_W  = $clog2(SSIZE + 1);
   localparam logic [RC_W-1:0]      LAST_RC = RC_W'(SSIZE - 1);
   localparam logic [CW-1:0]        SUP_C   = CW'(SUPPORT);
   localparam logic [IDX_WIDTH-1:0] SSIZE_I = IDX_WIDTH'(SSIZE);

   typedef enum logic {IDLE, RUN} stateT;

   stateT                r_state;
   logic [CW-1:0]        r_iu, r_iv;
   logic [IDX_WIDTH-1:0] r_offset;
   logic [PRECISION-1:0] r_dataR, r_dataI;
   logic [RC_W-1:0]      r_row, r_col;
   logic                 r_valid;
   logic [IDX_WIDTH-1:0] r_gind, r_cind;
   logic [PRECISION-1:0] r_outR, r_outI;
   logic [15:0]          r_count;

   stateT                w_nState;
   logic [CW-1:0]        w_nIu, w_nIv, w_u, w_v;
   logic [IDX_WIDTH-1:0] w_nOffset, w_gind, w_cind;
   logic [PRECISION-1:0] w_nDataR, w_nDataI;
   logic [RC_W-1:0]      w_nRow, w_nCol;
   logic                 w_advance, w_last, w_inGrid, w_nValid;
   logic                 w_unused;

   // Only the low CW bits of the cell coordinates take part in the arithmetic.
   assign w_unused = ^{iu[IDX_WIDTH-1:CW], iv[IDX_WIDTH-1:CW]};

   // r_valid doubles as the in-grid flag of the beat currently presented.
   assign w_advance = (r_state == RUN) && (!r_valid || out_ready);
   assign w_last    = w_advance && (r_row == LAST_RC) && (r_col == LAST_RC);
   assign read      = !rst && !empty && ((r_state == IDLE) || w_last);

   always_comb begin
      w_nState  = r_state;
      w_nIu     = r_iu;
      w_nIv     = r_iv;
      w_nOffset = r_offset;
      w_nDataR  = r_dataR;
      w_nDataI  = r_dataI;
      w_nRow    = r_row;
      w_nCol    = r_col;
      if (read) begin
         w_nState  = RUN;
         w_nIu     = iu[CW-1:0];
         w_nIv     = iv[CW-1:0];
         w_nOffset = offset;
         w_nDataR  = indatar;
         w_nDataI  = indatai;
         w_nRow    = '0;
         w_nCol    = '0;
      end else if (w_last) begin
         w_nState = IDLE;
      end else if (w_advance) begin
         if (r_col == LAST_RC) begin
            w_nCol = '0;
            w_nRow = r_row + RC_W'(1);
         end else begin
            w_nCol = r_col + RC_W'(1);
         end
      end
   end

   // Output registers are loaded with the beat the next state will present.
   always_comb begin
      w_u      = w_nIu - SUP_C + CW'(w_nCol);
      w_v      = w_nIv - SUP_C + CW'(w_nRow);
      w_inGrid = WRAP ? 1'b1 : ((w_u[CW-1:CW-2] == 2'b00) && (w_v[CW-1:CW-2] == 2'b00));
      w_nValid = (w_nState == RUN) && w_inGrid;
      w_gind   = IDX_WIDTH'({w_v[GSIZE_BITS-1:0], w_u[GSIZE_BITS-1:0]});
      w_cind   = w_nOffset + IDX_WIDTH'(w_nRow) * SSIZE_I + IDX_WIDTH'(w_nCol);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_iu     <= '0;
         r_iv     <= '0;
         r_offset <= '0;
         r_dataR  <= '0;
         r_dataI  <= '0;
         r_row    <= '0;
         r_col    <= '0;
         r_valid  <= 1'b0;
         r_gind   <= '0;
         r_cind   <= '0;
         r_outR   <= '0;
         r_outI   <= '0;
         r_count  <= '0;
      end else begin
         r_state  <= w_nState;
         r_iu     <= w_nIu;
         r_iv     <= w_nIv;
         r_offset <= w_nOffset;
         r_dataR  <= w_nDataR;
         r_dataI  <= w_nDataI;
         r_row    <= w_nRow;
         r_col    <= w_nCol;
         r_valid  <= w_nValid;
         if (w_nValid) begin
            r_gind <= w_gind;
            r_cind <= w_cind;
         end
         r_outR <= w_nValid ? w_nDataR : '0;
         r_outI <= w_nValid ? w_nDataI : '0;
         if (w_last) r_count <= r_count + 16'd1;
      end
   end

   assign valid        = r_valid;
   assign gind         = r_gind;
   assign cind         = r_cind;
   assign outdatar     = r_outR;
   assign outdatai     = r_outI;
   assign busy         = (r_state == RUN);
   assign sample_count = r_count;

endmodule

// File: tb/tb_grid_scatter_2d.sv
// Directed bench for grid_scatter_2d: a wrapping instance (A) and a clipping
// instance (B), both SUPPORT=1 on a 32x32 grid, sharing sample inputs.
module tb_grid_scatter_2d;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        emptyA = 1'b1, emptyB = 1'b1;
   logic [15:0] iu = '0, iv = '0, offset = '0;
   logic [31:0] indatar = '0, indatai = '0;
   logic        outReady = 1'b1;

   logic        readA, validA, busyA;
   logic [15:0] gindA, cindA, countA;
   logic [31:0] outrA, outiA;
   logic        readB, validB, busyB;
   logic [15:0] gindB, cindB, countB;
   logic [31:0] outrB, outiB;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   grid_scatter_2d #(.GSIZE_BITS(5), .SUPPORT(1), .PRECISION(32), .IDX_WIDTH(16), .WRAP(1'b1)) dutWrap (
      .clk(clk), .rst(rst), .empty(emptyA), .iu(iu), .iv(iv), .offset(offset),
      .indatar(indatar), .indatai(indatai), .read(readA), .out_ready(outReady),
      .valid(validA), .gind(gindA), .cind(cindA), .outdatar(outrA), .outdatai(outiA),
      .busy(busyA), .sample_count(countA));

   grid_scatter_2d #(.GSIZE_BITS(5), .SUPPORT(1), .PRECISION(32), .IDX_WIDTH(16), .WRAP(1'b0)) dutClip (
      .clk(clk), .rst(rst), .empty(emptyB), .iu(iu), .iv(iv), .offset(offset),
      .indatar(indatar), .indatai(indatai), .read(readB), .out_ready(outReady),
      .valid(validB), .gind(gindB), .cind(cindB), .outdatar(outrB), .outdatai(outiB),
      .busy(busyB), .sample_count(countB));

   task automatic applyStimulus(input logic [15:0] u, input logic [15:0] v, input logic [15:0] off,
                                input logic [31:0] dr, input logic [31:0] di);
      iu = u; iv = v; offset = off; indatar = dr; indatai = di;
   endtask

   task automatic test_reset;
      rst = 1'b1; emptyA = 1'b0; emptyB = 1'b0; outReady = 1'b1;
      applyStimulus(16'd10, 16'd20, 16'd0, 32'h11, 32'h22);
      repeat (2) @(posedge clk);
      #1;
      checks++; if (readA !== 1'b0) begin failures++; $display("[TB] FAIL reset_readA got=%0b exp=0", readA); end
      checks++; if (readB !== 1'b0) begin failures++; $display("[TB] FAIL reset_readB got=%0b exp=0", readB); end
      checks++; if (validA !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%0b exp=0", validA); end
      checks++; if (busyA !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%0b exp=0", busyA); end
      checks++; if (countA !== 16'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", countA); end
      checks++; if (gindA !== 16'd0 || cindA !== 16'd0) begin failures++; $display("[TB] FAIL reset_idx got=%0d/%0d exp=0/0", gindA, cindA); end
      checks++; if (outrA !== 32'd0 || outiA !== 32'd0) begin failures++; $display("[TB] FAIL reset_data got=%h/%h exp=0/0", outrA, outiA); end
      rst = 1'b0; emptyA = 1'b1; emptyB = 1'b1;
      @(posedge clk); #1;
      checks++; if (busyA !== 1'b0) begin failures++; $display("[TB] FAIL idle_busy got=%0b exp=0", busyA); end
   endtask

   task automatic test_basic;
      logic [15:0] expG [9] = '{16'd617, 16'd618, 16'd619, 16'd649, 16'd650, 16'd651, 16'd681, 16'd682, 16'd683};
      applyStimulus(16'd10, 16'd20, 16'd0, 32'h11, 32'h22);
      emptyA = 1'b0; #1;
      checks++; if (readA !== 1'b1) begin failures++; $display("[TB] FAIL basic_read got=%0b exp=1", readA); end
      @(posedge clk); #1; emptyA = 1'b1;
      for (int i = 0; i < 9; i++) begin
         checks++; if (validA !== 1'b1) begin failures++; $display("[TB] FAIL basic_valid beat=%0d got=%0b exp=1", i, validA); end
         checks++; if (gindA !== expG[i]) begin failures++; $display("[TB] FAIL basic_gind beat=%0d got=%0d exp=%0d", i, gindA, expG[i]); end
         checks++; if (cindA !== 16'(i)) begin failures++; $display("[TB] FAIL basic_cind beat=%0d got=%0d exp=%0d", i, cindA, i); end
         checks++; if (outrA !== 32'h11 || outiA !== 32'h22) begin failures++; $display("[TB] FAIL basic_data beat=%0d got=%h/%h exp=11/22", i, outrA, outiA); end
         @(posedge clk); #1;
      end
      checks++; if (validA !== 1'b0 || busyA !== 1'b0) begin failures++; $display("[TB] FAIL basic_end valid/busy got=%0b/%0b exp=0/0", validA, busyA); end
      checks++; if (outrA !== 32'd0) begin failures++; $display("[TB] FAIL basic_zero_data got=%h exp=0", outrA); end
      checks++; if (countA !== 16'd1) begin failures++; $display("[TB] FAIL basic_count got=%0d exp=1", countA); end
   endtask

   task automatic test_wrap;
      logic [15:0] expG [9] = '{16'd1023, 16'd992, 16'd993, 16'd31, 16'd0, 16'd1, 16'd63, 16'd32, 16'd33};
      applyStimulus(16'd0, 16'd0, 16'd0, 32'h1, 32'h2);
      emptyA = 1'b0; #1;
      @(posedge clk); #1; emptyA = 1'b1;
      for (int i = 0; i < 9; i++) begin
         checks++; if (validA !== 1'b1 || gindA !== expG[i]) begin failures++; $display("[TB] FAIL wrap_gind beat=%0d got=%0d(v%0b) exp=%0d", i, gindA, validA, expG[i]); end
         @(posedge clk); #1;
      end
      checks++; if (countA !== 16'd2) begin failures++; $display("[TB] FAIL wrap_count got=%0d exp=2", countA); end
   endtask

   task automatic test_clip;
      logic [15:0] expG [4] = '{16'd0, 16'd1, 16'd32, 16'd33};
      logic [15:0] expC [4] = '{16'd104, 16'd105, 16'd107, 16'd108};
      int nv = 0;
      int busyCycles = 0;
      applyStimulus(16'd0, 16'd0, 16'd100, 32'h33, 32'h44);
      emptyB = 1'b0; #1;
      checks++; if (readB !== 1'b1) begin failures++; $display("[TB] FAIL clip_read got=%0b exp=1", readB); end
      @(posedge clk); #1; emptyB = 1'b1;
      for (int t = 0; t < 12; t++) begin
         if (busyB) busyCycles++;
         if (validB) begin
            if (nv < 4) begin
               checks++; if (gindB !== expG[nv] || cindB !== expC[nv]) begin failures++; $display("[TB] FAIL clip_beat n=%0d got=%0d/%0d exp=%0d/%0d", nv, gindB, cindB, expG[nv], expC[nv]); end
            end
            nv++;
         end
         @(posedge clk); #1;
      end
      checks++; if (nv !== 4) begin failures++; $display("[TB] FAIL clip_nbeats got=%0d exp=4", nv); end
      checks++; if (busyCycles !== 9) begin failures++; $display("[TB] FAIL clip_busy got=%0d exp=9", busyCycles); end
      checks++; if (countB !== 16'd1) begin failures++; $display("[TB] FAIL clip_count got=%0d exp=1", countB); end
   endtask

   task automatic test_backpressure;
      logic [15:0] expG [9] = '{16'd617, 16'd618, 16'd619, 16'd649, 16'd650, 16'd651, 16'd681, 16'd682, 16'd683};
      int acc = 0;
      int stall = 0;
      applyStimulus(16'd10, 16'd20, 16'd0, 32'h11, 32'h22);
      emptyA = 1'b0; #1;
      @(posedge clk); #1; emptyA = 1'b1;
      for (int t = 0; t < 40 && acc < 9; t++) begin
         outReady = !(t >= 1 && t <= 3);
         if (validA && gindA == 16'd618) stall++;
         if (t >= 1 && t <= 4) begin
            checks++; if (validA !== 1'b1 || gindA !== 16'd618 || cindA !== 16'd1) begin failures++; $display("[TB] FAIL bp_hold t=%0d got=%0b/%0d/%0d exp=1/618/1", t, validA, gindA, cindA); end
         end
         if (validA && outReady) begin
            checks++; if (gindA !== expG[acc] || cindA !== 16'(acc)) begin failures++; $display("[TB] FAIL bp_beat n=%0d got=%0d/%0d exp=%0d/%0d", acc, gindA, cindA, expG[acc], acc); end
            acc++;
         end
         @(posedge clk); #1;
      end
      outReady = 1'b1;
      checks++; if (acc !== 9) begin failures++; $display("[TB] FAIL bp_total got=%0d exp=9", acc); end
      checks++; if (stall !== 4) begin failures++; $display("[TB] FAIL bp_stable got=%0d exp=4", stall); end
      checks++; if (validA !== 1'b0 || countA !== 16'd3) begin failures++; $display("[TB] FAIL bp_end valid/count got=%0b/%0d exp=0/3", validA, countA); end
   endtask

   task automatic test_toggle;
      logic [15:0] expG [9] = '{16'd990, 16'd991, 16'd960, 16'd1022, 16'd1023, 16'd992, 16'd30, 16'd31, 16'd0};
      int acc = 0;
      applyStimulus(16'd31, 16'd31, 16'd7, 32'h5, 32'h6);
      emptyA = 1'b0; #1;
      @(posedge clk); #1; emptyA = 1'b1;
      for (int t = 0; t < 40 && acc < 9; t++) begin
         outReady = (t % 2 == 1);
         if (validA && outReady) begin
            checks++; if (gindA !== expG[acc] || cindA !== 16'(acc + 7)) begin failures++; $display("[TB] FAIL toggle_beat n=%0d got=%0d/%0d exp=%0d/%0d", acc, gindA, cindA, expG[acc], acc + 7); end
            acc++;
         end
         @(posedge clk); #1;
      end
      outReady = 1'b1;
      checks++; if (acc !== 9 || validA !== 1'b0) begin failures++; $display("[TB] FAIL toggle_total got=%0d(v%0b) exp=9(v0)", acc, validA); end
      checks++; if (countA !== 16'd4) begin failures++; $display("[TB] FAIL toggle_count got=%0d exp=4", countA); end
   endtask

   task automatic test_back_to_back;
      int head = 0;
      logic rd;
      logic expRead, expValid;
      for (int t = 0; t < 20; t++) begin
         if (head == 0) begin applyStimulus(16'd10, 16'd20, 16'd0, 32'h11, 32'h22); emptyA = 1'b0; end
         else if (head == 1) begin applyStimulus(16'd5, 16'd6, 16'd50, 32'h77, 32'h88); emptyA = 1'b0; end
         else emptyA = 1'b1;
         #1;
         expRead = (t == 0 || t == 9);
         expValid = (t >= 1 && t <= 18);
         checks++; if (readA !== expRead) begin failures++; $display("[TB] FAIL b2b_read t=%0d got=%0b exp=%0b", t, readA, expRead); end
         checks++; if (validA !== expValid) begin failures++; $display("[TB] FAIL b2b_valid t=%0d got=%0b exp=%0b", t, validA, expValid); end
         if (t == 10) begin
            checks++; if (gindA !== 16'd164 || cindA !== 16'd50 || outrA !== 32'h77) begin failures++; $display("[TB] FAIL b2b_first2 got=%0d/%0d/%h exp=164/50/77", gindA, cindA, outrA); end
         end
         if (t == 18) begin
            checks++; if (gindA !== 16'd230 || cindA !== 16'd58) begin failures++; $display("[TB] FAIL b2b_last2 got=%0d/%0d exp=230/58", gindA, cindA); end
         end
         rd = readA;
         @(posedge clk);
         if (rd) head++;
         #1;
      end
      emptyA = 1'b1;
      checks++; if (countA !== 16'd6) begin failures++; $display("[TB] FAIL b2b_count got=%0d exp=6", countA); end
   endtask

   task automatic test_reset_mid;
      applyStimulus(16'd10, 16'd20, 16'd0, 32'h11, 32'h22);
      emptyA = 1'b0; #1;
      @(posedge clk); #1; emptyA = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (validA !== 1'b1 || cindA !== 16'd3) begin failures++; $display("[TB] FAIL mid_beat4 got=%0b/%0d exp=1/3", validA, cindA); end
      rst = 1'b1;
      applyStimulus(16'd3, 16'd4, 16'd200, 32'h55, 32'h66);
      emptyA = 1'b0; #1;
      checks++; if (readA !== 1'b0) begin failures++; $display("[TB] FAIL mid_read_rst got=%0b exp=0", readA); end
      @(posedge clk); #1;
      checks++; if (validA !== 1'b0 || busyA !== 1'b0) begin failures++; $display("[TB] FAIL mid_valid got=%0b/%0b exp=0/0", validA, busyA); end
      checks++; if (countA !== 16'd0) begin failures++; $display("[TB] FAIL mid_count got=%0d exp=0", countA); end
      checks++; if (readA !== 1'b0) begin failures++; $display("[TB] FAIL mid_read_hold got=%0b exp=0", readA); end
      rst = 1'b0; #1;
      checks++; if (readA !== 1'b1) begin failures++; $display("[TB] FAIL mid_repop got=%0b exp=1", readA); end
      @(posedge clk); #1; emptyA = 1'b1;
      checks++; if (validA !== 1'b1 || gindA !== 16'd98 || cindA !== 16'd200 || outrA !== 32'h55) begin failures++; $display("[TB] FAIL mid_first got=%0b/%0d/%0d/%h exp=1/98/200/55", validA, gindA, cindA, outrA); end
      repeat (8) @(posedge clk);
      #1;
      checks++; if (validA !== 1'b1 || gindA !== 16'd164 || cindA !== 16'd208) begin failures++; $display("[TB] FAIL mid_last got=%0b/%0d/%0d exp=1/164/208", validA, gindA, cindA); end
      @(posedge clk); #1;
      checks++; if (countA !== 16'd1 || busyA !== 1'b0) begin failures++; $display("[TB] FAIL mid_end count/busy got=%0d/%0b exp=1/0", countA, busyA); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_clip();
      test_backpressure();
      test_toggle();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/grid_scatter_2d.md
Name: grid_scatter_2d

Overview:
- Parametrised successor of the visibility gridding front-end.
- Pops one visibility sample (iu, iv, kernel offset, complex data) from a first-word-fall-through FIFO.
- Walks the full 2-D SSIZE x SSIZE convolution support and emits one (grid index, kernel index, data) beat per support point to the accumulate stage.
- Adds over the earlier one-dimensional walker:
  - downstream ready/valid backpressure;
  - grid-edge wrap or clip mode;
  - no-bubble back-to-back sample processing;
  - a completed-sample counter.

Parameters:
- GSIZE_BITS, 5, log2 of grid side; GSIZE = 2**GSIZE_BITS, range 2..8.
- SUPPORT, 7, kernel half-width; SSIZE = 2*SUPPORT+1; SUPPORT < GSIZE/2.
- PRECISION, 32, width of each of the real and imaginary data words.
- IDX_WIDTH, 16, width of the iu, iv, offset, gind and cind ports.
- WRAP, 1:
  - 1 = grid coordinates taken modulo GSIZE;
  - 0 = out-of-grid support points are suppressed.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- empty  in  1  FIFO empty flag.
- iu  in  IDX_WIDTH  sample u cell; valid range 0..GSIZE-1.
- iv  in  IDX_WIDTH  sample v cell; valid range 0..GSIZE-1.
- offset  in  IDX_WIDTH  kernel base index for this sample.
- indatar  in  PRECISION  sample real part.
- indatai  in  PRECISION  sample imaginary part.
- read  out  1  combinational pop; FIFO advances on the clk edge where read=1.
- out_ready  in  1  downstream accepts the beat this cycle.
- valid  out  1  beat on gind/cind/outdata is valid.
- gind  out  IDX_WIDTH  grid index = v*GSIZE + u.
- cind  out  IDX_WIDTH  kernel index = offset + r*SSIZE + c.
- outdatar  out  PRECISION  latched real part when valid=1, else 0.
- outdatai  out  PRECISION  latched imaginary part when valid=1, else 0.
- busy  out  1  1 while a sample is being walked.
- sample_count  out  16  number of completed samples; wraps at 65535 to 0.

Behaviour:
- FSM states:
  - IDLE: no sample held.
  - RUN: a sample is latched; beat counters r (row) and c (column) each run 0..SSIZE-1.
- Beat coordinates, computed as signed GSIZE_BITS+2 bit values:
  - u = iu - SUPPORT + c;
  - v = iv - SUPPORT + r.
- WRAP=1:
  - u and v are taken mod GSIZE (low GSIZE_BITS bits);
  - every beat is in-grid.
- WRAP=0: a beat is in-grid only when 0 <= u < GSIZE and 0 <= v < GSIZE.
- gind = v*GSIZE + u, zero-extended to IDX_WIDTH.
- cind = offset + r*SSIZE + c, mod 2**IDX_WIDTH.
- gind, cind, valid and outdata are registered.
- valid = RUN and current beat in-grid.
- gind/cind hold their last value when valid=0, so a bench must not check them then.
- Beat advance:
  - advance = RUN and (not in-grid, or out_ready=1);
  - an out-of-grid beat is discarded in 1 cycle;
  - a valid beat holds all outputs stable until out_ready=1.
- Counter order: c increments first; at c = SSIZE-1 it returns to 0 and r increments.
- last = advance and r = c = SSIZE-1.
- read = !empty and (IDLE or last).
- On a pop edge, the block latches iu/iv/offset/data, sets r = c = 0 and enters or stays in RUN.
- Latency: first beat is presented the cycle after the pop.
- Without a pop: IDLE stays IDLE; on last without a pop, RUN goes to IDLE.
- Back-to-back samples: no bubble between the last beat of one sample and the first beat of the next.
- sample_count increments on every last.
- busy = (state == RUN).
- Reset:
  - state IDLE; valid 0; gind, cind, outdatar, outdatai 0; r = c = 0; sample_count 0; busy 0;
  - read is 0 while rst=1;
  - a reset mid-sample abandons that sample without re-popping it.
- Boundaries:
  - empty=1 on last: go to IDLE; no read.
  - out_ready=0 indefinitely: block stalls; no further read.
  - out_ready toggling each cycle: every beat is delivered exactly once.
  - iu or iv >= GSIZE: result is the same low-bit arithmetic; no error flagging.
- Throughput:
  - WRAP=1: SSIZE*SSIZE cycles per sample at out_ready=1.
  - WRAP=0: the same, including suppressed cycles.

Test Plan:
- Basic walk:
  - Setup: SUPPORT=1, GSIZE_BITS=5, WRAP=1; one sample iu=10, iv=20, offset=0, data 0x11/0x22; out_ready=1.
  - Response: read for 1 cycle; 9 consecutive valid beats.
  - First beat: gind=617, cind=0.
  - Fifth beat: gind=650, cind=4.
  - Ninth beat: gind=683, cind=8.
  - Data equals 0x11/0x22 on every beat; then IDLE, sample_count=1.
- Wrap:
  - Setup: WRAP=1, iu=0, iv=0.
  - Response: first gind=1023 (v=31, u=31); second gind=992; ninth gind=33.
- Clip:
  - Setup: WRAP=0, iu=0, iv=0, offset=100.
  - Response: exactly 4 valid beats, with gind 0,1,32,33 and cind 104,105,107,108.
  - busy lasts 9 cycles.
- Backpressure:
  - Setup: drop out_ready for 3 cycles while beat 2 (gind=618) is presented.
  - Response: valid, gind and cind stay stable for 4 cycles; no beat is lost or duplicated; 9 beats total.
- Back-to-back:
  - Setup: two samples queued, out_ready=1.
  - Response: read high at cycles 0 and 9; valid high cycles 1..18 with no gap; sample_count=2.
- Reset mid-sample:
  - Setup: assert rst during beat 4.
  - Response: valid=0 and sample_count=0 next cycle; no read while rst=1.
  - After release with empty=0: a new pop and a clean walk from cind=offset.
